// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Purpose  : Round-robin sharing of one spi_master between REQ_N requesters.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int REQ_N    = 4,
    parameter int START_TO = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_N-1:0]     req,
    input  logic [32*REQ_N-1:0]  req_tx_data,
    input  logic [3*REQ_N-1:0]   req_cs_sel,
    input  logic [2*REQ_N-1:0]   req_len,
    input  logic [4*REQ_N-1:0]   req_clkdiv,
    input  logic [REQ_N-1:0]     req_cpol,
    input  logic [REQ_N-1:0]     req_cpha,
    output logic [REQ_N-1:0]     grant,
    output logic [REQ_N-1:0]     done,
    output logic                 err,
    output logic [31:0]          rx_data,
    output logic                 arb_busy,
    output logic                 m_start,
    input  logic                 m_busy,
    output logic [31:0]          m_tx_data,
    input  logic [31:0]          m_rx_data,
    output logic [2:0]           m_cs_sel,
    output logic [1:0]           m_len,
    output logic [3:0]           m_clkdiv,
    output logic                 m_cpol,
    output logic                 m_cpha
);

    localparam int c_PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int c_CW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [c_CW-1:0]  c_TO_LAST = c_CW'(START_TO - 1);
    localparam logic [REQ_N-1:0] c_ONE     = REQ_N'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [c_PW-1:0]  r_ptr;
    logic [c_PW-1:0]  r_win;
    logic [c_CW-1:0]  r_cnt;
    logic [REQ_N-1:0] r_grant;
    logic [REQ_N-1:0] r_done;
    logic             r_err;
    logic [31:0]      r_rx;
    logic             r_busy;
    logic             r_start;
    logic [31:0]      r_tx;
    logic [2:0]       r_cs;
    logic [1:0]       r_len;
    logic [3:0]       r_div;
    logic             r_cpol;
    logic             r_cpha;

    logic [31:0] w_tx  [REQ_N];
    logic [2:0]  w_cs  [REQ_N];
    logic [1:0]  w_len [REQ_N];
    logic [3:0]  w_div [REQ_N];

    generate
        for (genvar gi = 0; gi < REQ_N; gi++) begin : g_unpack
            assign w_tx[gi]  = req_tx_data[32*gi +: 32];
            assign w_cs[gi]  = req_cs_sel[3*gi +: 3];
            assign w_len[gi] = req_len[2*gi +: 2];
            assign w_div[gi] = req_clkdiv[4*gi +: 4];
        end
    endgenerate

    // First set request at or above the pointer, wrapping modulo REQ_N.
    logic [c_PW:0]   w_sum;
    logic [c_PW-1:0] w_win;
    logic            w_found;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < REQ_N; k++) begin
            w_sum = {1'b0, r_ptr} + (c_PW+1)'(k);
            if (w_sum >= (c_PW+1)'(REQ_N)) begin
                w_sum = w_sum - (c_PW+1)'(REQ_N);
            end
            if (!w_found && req[w_sum[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_PW-1:0];
            end
        end
    end

    logic [c_PW-1:0] w_ptr_next;
    assign w_ptr_next = (r_win == c_PW'(REQ_N - 1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rx    <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_tx    <= '0;
            r_cs    <= '0;
            r_len   <= '0;
            r_div   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_state <= c_START;
                        r_busy  <= 1'b1;
                        r_grant <= c_ONE << w_win;
                        r_win   <= w_win;
                        r_tx    <= w_tx[w_win];
                        r_cs    <= w_cs[w_win];
                        r_len   <= w_len[w_win];
                        r_div   <= w_div[w_win];
                        r_cpol  <= req_cpol[w_win];
                        r_cpha  <= req_cpha[w_win];
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                c_START: begin
                    if (m_busy) begin
                        r_state <= c_RUN;
                        r_start <= 1'b0;
                    end else if (r_cnt == c_TO_LAST) begin
                        // Master never acknowledged: finish with err, keep old rx word.
                        r_start <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= r_grant;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RUN: begin
                    if (!m_busy) begin
                        r_state <= c_DONE;
                        r_rx    <= m_rx_data;
                        r_done  <= r_grant;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_ptr   <= w_ptr_next;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign rx_data   = r_rx;
    assign arb_busy  = r_busy;
    assign m_start   = r_start;
    assign m_tx_data = r_tx;
    assign m_cs_sel  = r_cs;
    assign m_len     = r_len;
    assign m_clkdiv  = r_div;
    assign m_cpol    = r_cpol;
    assign m_cpha    = r_cpha;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Purpose  : Self-checking bench for spi_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int REQ_N    = 4;
    localparam int START_TO = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [REQ_N-1:0]    req;
    logic [32*REQ_N-1:0] req_tx_data;
    logic [3*REQ_N-1:0]  req_cs_sel;
    logic [2*REQ_N-1:0]  req_len;
    logic [4*REQ_N-1:0]  req_clkdiv;
    logic [REQ_N-1:0]    req_cpol;
    logic [REQ_N-1:0]    req_cpha;
    logic [REQ_N-1:0]    grant;
    logic [REQ_N-1:0]    done;
    logic                err;
    logic [31:0]         rx_data;
    logic                arb_busy;
    logic                m_start;
    logic                m_busy;
    logic [31:0]         m_tx_data;
    logic [31:0]         m_rx_data;
    logic [2:0]          m_cs_sel;
    logic [1:0]          m_len;
    logic [3:0]          m_clkdiv;
    logic                m_cpol;
    logic                m_cpha;

    spi_arbiter #(.REQ_N(REQ_N), .START_TO(START_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tx_data(req_tx_data),
        .req_cs_sel(req_cs_sel), .req_len(req_len), .req_clkdiv(req_clkdiv),
        .req_cpol(req_cpol), .req_cpha(req_cpha), .grant(grant), .done(done),
        .err(err), .rx_data(rx_data), .arb_busy(arb_busy), .m_start(m_start),
        .m_busy(m_busy), .m_tx_data(m_tx_data), .m_rx_data(m_rx_data),
        .m_cs_sel(m_cs_sel), .m_len(m_len), .m_clkdiv(m_clkdiv),
        .m_cpol(m_cpol), .m_cpha(m_cpha)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int         md_owner;     // requester currently served, -1 when none
    int         md_ptr;       // where the next search begins
    int         md_wait;      // cycles m_start has been shown so far
    bit         md_acked;     // master raised busy for this transaction
    bit         md_closing;   // completion pulse is being shown this cycle
    logic [3:0]  e_grant, e_done, e_div;
    logic        e_err, e_busy, e_start, e_cpol, e_cpha;
    logic [31:0] e_rx, e_tx;
    logic [2:0]  e_cs;
    logic [1:0]  e_len;

    task automatic model_reset();
        md_owner = -1; md_ptr = 0; md_wait = 0; md_acked = 1'b0; md_closing = 1'b0;
        e_grant = '0; e_done = '0; e_err = 1'b0; e_busy = 1'b0; e_start = 1'b0;
        e_rx = '0; e_tx = '0; e_cs = '0; e_len = '0; e_div = '0; e_cpol = 1'b0; e_cpha = 1'b0;
    endtask

    task automatic model_step();
        int  w;
        bit  found;
        e_done = '0;
        e_err  = 1'b0;
        if (md_closing) begin
            md_closing = 1'b0;
            md_ptr     = (md_owner + 1) % REQ_N;
            md_owner   = -1;
            e_grant    = '0;
            e_busy     = 1'b0;
        end else if (md_owner < 0) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < REQ_N; k++) begin
                if (!found && req[(md_ptr + k) % REQ_N]) begin
                    found = 1'b1;
                    w     = (md_ptr + k) % REQ_N;
                end
            end
            if (found) begin
                md_owner = w;
                e_grant  = 4'(1 << w);
                e_tx     = req_tx_data[32*w +: 32];
                e_cs     = req_cs_sel[3*w +: 3];
                e_len    = req_len[2*w +: 2];
                e_div    = req_clkdiv[4*w +: 4];
                e_cpol   = req_cpol[w];
                e_cpha   = req_cpha[w];
                e_start  = 1'b1;
                e_busy   = 1'b1;
                md_wait  = 1;
                md_acked = 1'b0;
            end
        end else if (!md_acked) begin
            if (m_busy) begin
                md_acked = 1'b1;
                e_start  = 1'b0;
            end else if (md_wait == START_TO) begin
                e_start    = 1'b0;
                e_done     = e_grant;
                e_err      = 1'b1;
                md_closing = 1'b1;
            end else begin
                md_wait++;
            end
        end else if (!m_busy) begin
            e_done     = e_grant;
            e_rx       = m_rx_data;
            md_closing = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [85:0] act, exp;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                act = {grant, done, err, rx_data, arb_busy, m_start, m_tx_data,
                       m_cs_sel, m_len, m_clkdiv, m_cpol, m_cpha};
                exp = {e_grant, e_done, e_err, e_rx, e_busy, e_start, e_tx,
                       e_cs, e_len, e_div, e_cpol, e_cpha};
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL cycle_model @%0t: got %h, expected %h", $time, act, exp);
                end
            end
        end
    end

    // ---------------- spi_master stand-in ----------------
    int  em_ph = 0, em_cnt = 0;
    int  em_dmax = 0, em_lmin = 2, em_lmax = 4;
    bit  em_nobusy = 1'b0, em_rand_to = 1'b0;
    logic [31:0] slave_q[$];

    task automatic raise_busy();
        m_busy    = 1'b1;
        m_rx_data = $urandom;
        em_cnt    = $urandom_range(em_lmax, em_lmin);
        em_ph     = 2;
    endtask

    initial begin
        m_busy    = 1'b0;
        m_rx_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                em_ph  = 0;
                m_busy = 1'b0;
            end else begin
                case (em_ph)
                    0: if (m_start === 1'b1) begin
                        if (em_nobusy || (em_rand_to && $urandom_range(7, 0) == 0)) begin
                            em_ph = 3;
                        end else begin
                            em_cnt = $urandom_range(em_dmax, 0);
                            if (em_cnt == 0) raise_busy();
                            else             em_ph = 1;
                        end
                    end
                    1: begin
                        em_cnt--;
                        if (em_cnt == 0) raise_busy();
                    end
                    2: begin
                        em_cnt--;
                        if (em_cnt == 0) begin
                            m_busy = 1'b0;
                            if (slave_q.size() > 0) m_rx_data = slave_q.pop_front();
                            else                    m_rx_data = $urandom;
                            em_ph = 0;
                        end
                    end
                    3: if (m_start !== 1'b1) em_ph = 0;
                    default: em_ph = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int i, input logic [31:0] tx, input logic [2:0] cs,
                           input logic [1:0] len, input logic [3:0] div,
                           input logic pol, input logic pha);
        req_tx_data[32*i +: 32] = tx;
        req_cs_sel[3*i +: 3]    = cs;
        req_len[2*i +: 2]       = len;
        req_clkdiv[4*i +: 4]    = div;
        req_cpol[i]             = pol;
        req_cpha[i]             = pha;
    endtask

    task automatic wait_done(input int bound, output logic [3:0] d, output logic e);
        d = '0;
        e = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done != '0) begin
                d = done;
                e = err;
                return;
            end
            @(negedge clk);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_done: got no done within %0d cycles, expected a pulse", bound);
    endtask

    task automatic wait_grant(input int bound, output logic [3:0] g);
        g = '0;
        for (int i = 0; i < bound; i++) begin
            if (grant != '0) begin
                g = grant;
                return;
            end
            @(negedge clk);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_grant: got no grant within %0d cycles, expected a grant", bound);
    endtask

    task automatic wait_busy(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (m_busy) return;
            @(negedge clk);
        end
        n_tests++; n_fail++;
        $display("FAIL wait_busy: got no m_busy within %0d cycles, expected busy", bound);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random sequences ----------------
    initial begin
        logic [3:0] d, g;
        logic       e;
        logic [3:0] rr_seq [5];
        int         cnt;

        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

        rst = 1'b1; req = '0; req_tx_data = '0; req_cs_sel = '0; req_len = '0;
        req_clkdiv = '0; req_cpol = '0; req_cpha = '0;
        #1 rst = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_busy_start", {arb_busy, m_start, done, err}, 0);
        check("reset_rx_tx", {rx_data, m_tx_data}, 0);
        rst = 1'b1;

        // Single requester
        @(negedge clk);
        set_cfg(0, 32'hAA, 3'd0, 2'd0, 4'd1, 1'b0, 1'b1);
        slave_q.push_back(32'hFB);
        req = 4'b0001;
        @(negedge clk);
        check("single_grant", grant, 4'b0001);
        check("single_start", m_start, 1);
        req = '0;
        wait_done(60, d, e);
        check("single_done", d, 4'b0001);
        check("single_rx", rx_data, 32'hFB);
        check("single_err", e, 0);
        @(negedge clk);
        check("single_done_once", done, 0);

        // Round-robin with all four requesting
        do_reset();
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(40, g);
            check($sformatf("rr_grant%0d", k), g, rr_seq[k]);
            check($sformatf("rr_model%0d", k), e_grant, rr_seq[k]);
            if (k == 4) req = '0;
            wait_done(60, d, e);
            @(negedge clk);
        end

        // Config latching against mid-transaction input changes
        set_cfg(2, 32'hC926A05C, 3'd5, 2'd3, 4'd2, 1'b1, 1'b0);
        slave_q.push_back(32'hF97632D4);
        em_lmin = 5; em_lmax = 8;
        req = 4'b0100;
        wait_grant(10, g);
        req = '0;
        wait_busy(10);
        req_tx_data[95:64] = 32'h12345678;
        req_len[5:4]       = 2'd0;
        wait_done(60, d, e);
        check("latch_tx", m_tx_data, 32'hC926A05C);
        check("latch_len", m_len, 2'd3);
        check("latch_rx", rx_data, 32'hF97632D4);

        // Start timeout
        @(negedge clk);
        em_nobusy = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        check("to_grant", grant, 4'b0010);
        req = '0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done != '0) break;
            if (m_start) cnt++;
            @(negedge clk);
        end
        check("to_start_cycles", cnt, START_TO);
        check("to_done_err", {done, err}, {4'b0010, 1'b1});
        check("to_rx_kept", rx_data, 32'hF97632D4);
        @(negedge clk);
        check("to_idle", {grant, arb_busy}, 0);
        em_nobusy = 1'b0;

        // Dropped request and back-to-back re-grant
        set_cfg(0, 32'h3C3C3C3C, 3'd2, 2'd3, 4'd4, 1'b1, 1'b1);
        set_cfg(1, 32'h0000ACD9, 3'd1, 2'd1, 4'd3, 1'b0, 1'b0);
        slave_q.push_back(32'h0BADF00D);
        slave_q.push_back(32'h00005D6A);
        em_lmin = 4; em_lmax = 6;
        req = 4'b0001;
        wait_grant(10, g);
        check("drop_grant", g, 4'b0001);
        wait_busy(10);
        req = 4'b0010;
        wait_done(60, d, e);
        check("drop_done", d, 4'b0001);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (grant != '0) break;
        end
        check("b2b_gap", cnt, 2);
        check("b2b_grant", grant, 4'b0010);
        req = '0;
        wait_done(60, d, e);
        check("b2b_rx", rx_data, 32'h5D6A);

        // Asynchronous reset during a 32-bit transfer
        @(negedge clk);
        set_cfg(2, 32'h89ABCDEF, 3'd1, 2'd3, 4'd5, 1'b0, 1'b1);
        em_lmin = 10; em_lmax = 12;
        req = 4'b0100;
        wait_grant(10, g);
        req = '0;
        wait_busy(10);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        req = 4'b0100;
        #1;
        check("rst_async_data", {rx_data, m_tx_data}, 0);
        check("rst_async_ctrl", {grant, done, err, arb_busy, m_start, m_cs_sel,
                                 m_len, m_clkdiv, m_cpol, m_cpha}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_regrant", grant, 4'b0100);
        req = '0;
        wait_done(60, d, e);

        // Randomized traffic with occasional timeouts
        em_dmax = 3; em_lmin = 1; em_lmax = 6; em_rand_to = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(3, 0) == 0) req = 4'($urandom);
            for (int i = 0; i < REQ_N; i++) begin
                if ($urandom_range(1, 0) == 1)
                    set_cfg(i, $urandom, 3'($urandom), 2'($urandom), 4'($urandom),
                            1'($urandom), 1'($urandom));
            end
        end
        req = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!arb_busy) break;
        end
        check("final_idle", arb_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_master` instance between `REQ_N` independent requesters. It arbitrates requests round-robin and latches the winner's transaction configuration onto the master's inputs. It sequences `start_trans`/`busy` and returns the received word with a one-cycle completion pulse to the granted requester. It sits between client logic (register files, sensor pollers) and the master's control/data ports.

## Interface
Parameters:
- `REQ_N`, 4: number of requesters (2..8).
- `START_TO`, 16: cycles to wait for `m_busy` to rise after `m_start` before aborting.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  REQ_N  per-requester transaction request (level).
- `req_tx_data`  in  32*REQ_N  tx word, requester i at [32i+31:32i].
- `req_cs_sel`  in  3*REQ_N  chip-select index.
- `req_len`  in  2*REQ_N  transaction length code (0=8, 1=16, 2=24, 3=32 bits).
- `req_clkdiv`  in  4*REQ_N  SCLK divider code.
- `req_cpol`, `req_cpha`  in  REQ_N each  SPI mode bits.
- `grant`  out  REQ_N  one-hot owner of the master; 0 when idle.
- `done`  out  REQ_N  one-cycle completion pulse to owner.
- `err`  out  1  one-cycle pulse together with `done` when the transaction aborted on timeout.
- `rx_data`  out  32  last received word; valid from the `done` cycle until the next `done`.
- `arb_busy`  out  1  high whenever the FSM is not IDLE.
- `m_start`  out  1  to master `start_trans`.
- `m_busy`  in  1  from master `busy`.
- `m_tx_data`  out  32  to master tx data.
- `m_rx_data`  in  32  from master rx data.
- `m_cs_sel`  out  3  to master chip-select index.
- `m_len`  out  2  to master transaction length.
- `m_clkdiv`  out  4  to master clock divider.
- `m_cpol`, `m_cpha`  out  1 each  to master mode bits.

## Operation
- FSM states: IDLE, START, RUN, DONE.
- IDLE: if any `req` bit is set, choose the first set bit searching from `ptr` upward with wrap (`ptr` = round-robin pointer, reset 0).
  - At that edge: go to START, `grant` <= one-hot of winner, latch winner's tx_data/cs_sel/len/clkdiv/cpol/cpha into `m_*` registers, `m_start` <= 1, timeout counter <= 0.
- START: hold `m_start`=1.
  - If `m_busy` is sampled 1: go to RUN and set `m_start` <= 0.
  - Else, if the counter equals `START_TO-1`: set `m_start` <= 0, set an abort flag, go to DONE.
  - Otherwise increment the counter.
- RUN: wait for `m_busy` sampled 0. Then go to DONE and set `rx_data` <= `m_rx_data`.
- DONE (one cycle):
  - `done` = `grant`; `err` = abort flag.
  - On an abort, `rx_data` keeps its previous value.
  - At the exit edge: `grant` <= 0, `ptr` <= (winner+1) mod `REQ_N`, abort flag cleared, go to IDLE.
- `m_*` config outputs are registered. They are stable from the grant edge through DONE and hold their last value in IDLE.
- `req` deassertion while granted is ignored; the transaction completes and `done` still pulses.
- A requester holding `req` high is served again only after every other pending requester has had a turn (fairness).
- Requester inputs are not sampled outside the grant edge. Changes mid-transaction have no effect.
- Reset (asynchronous, at any time including mid-transaction):
  - State goes to IDLE, `ptr`=0.
  - All outputs are 0: `grant`, `done`, `err`, `rx_data`, `arb_busy`, `m_start`, `m_tx_data`, `m_cs_sel`, `m_len`, `m_clkdiv`, `m_cpol`, `m_cpha`.
  - The master is reset by the same reset, so no transaction resumes.

## Timing
- Request to `grant`/`m_start` high: 1 cycle (registered, from the IDLE edge that samples `req`).
- `m_start` stays high from the grant edge until the edge after `m_busy` is first sampled 1, i.e. at least 1 cycle and at most `START_TO` cycles.
- `done` is asserted 1 cycle after `m_busy` is sampled low and lasts exactly 1 cycle.
- Earliest re-grant: IDLE lasts 1 cycle, so the next `grant` rises 2 cycles after the `done` cycle begins. This leaves the master at least 2 idle cycles between transactions.
- `arb_busy` = (state != IDLE), registered with the state.

## Test plan
- Single requester: req[0]=1, tx=0xAA, len=0, CPOL=0, CPHA=1, slave tx=0xFB, divider 1.
  - Required: grant=0001 and m_start high 1 cycle after req; done[0] pulses once; rx_data=0xFB; err=0.
- Round-robin: req=1111 held high for 5 transactions.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, with no grant overlap.
- Config latching: req[2], len=3, tx=0xC926A05C, slave tx=0xF97632D4; change req_tx_data[2] and req_len[2] mid-RUN.
  - Required: m_tx_data and m_len stay unchanged; rx_data=0xF97632D4.
- Timeout: tie m_busy=0 and raise req[1].
  - Required: m_start high exactly START_TO cycles; then done[1]=1 and err=1 in the same cycle; rx_data unchanged; FSM back to IDLE.
- Drop and back-to-back: req[0] deasserted during RUN.
  - Required: done[0] still pulses.
  - With req[1] pending, grant=0010 rises exactly 2 cycles after the done cycle starts; 16-bit tx 0xACD9 with slave 0x5D6A returns rx_data=0x5D6A.
- Reset mid-RUN: pull rst low during the 32-bit transfer.
  - Required: all outputs 0 immediately (asynchronous).
  - After release with req=0100, grant=0100, because ptr was reset to 0 and only requester 2 is requesting.
